// File: rtl/router_egress_deframer.sv
// Egress deframer: parses router packets (sa, da, len, crc, payload), validates length/CRC,
// and stores good payloads in a store-and-forward FIFO drained over a valid/ready byte port.
module router_egress_deframer #(
  parameter int MIN_LEN    = 12,
  parameter int MAX_LEN    = 64,
  parameter int FIFO_DEPTH = 128
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_last,
  input  logic        out_ready,
  output logic        pkt_done,
  output logic [2:0]  pkt_err,
  output logic [7:0]  sa_o,
  output logic [7:0]  da_o,
  output logic [31:0] len_o,
  output logic [15:0] pkt_count,
  output logic [15:0] err_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(FIFO_DEPTH);

  localparam logic [2:0] E_OK    = 3'd0;
  localparam logic [2:0] E_CRC   = 3'd1;
  localparam logic [2:0] E_SHORT = 3'd2;
  localparam logic [2:0] E_LONG  = 3'd3;
  localparam logic [2:0] E_TRUNC = 3'd4;
  localparam logic [2:0] E_OVR   = 3'd5;
  localparam logic [2:0] E_OVF   = 3'd6;

  typedef enum logic [2:0] {IDLE, HDR, PAY, DROP, DONE} state_t;
  state_t state_reg, state_next;

  logic [3:0]  hdr_idx_reg;
  logic [7:0]  sa_reg, da_reg, sum_reg, pay_cnt_reg;
  logic [31:0] len_reg, crc_reg;
  logic [2:0]  err_reg;
  logic [AW:0] wr_commit_reg, wr_spec_reg, rd_ptr_reg;
  logic [8:0]  mem [FIFO_DEPTH];

  logic        start, wr_en, wr_last, eop, set_err, fifo_full, rd_en;
  logic [2:0]  new_err, done_err;
  logic [31:0] len_full;
  logic [7:0]  pay_len;

  assign len_full  = {in_data, len_reg[23:0]};
  assign pay_len   = len_reg[7:0] - 8'd10;
  assign wr_last   = (pay_cnt_reg == pay_len - 8'd1);
  assign fifo_full = ((wr_spec_reg - rd_ptr_reg) == DEPTH_CNT);

  // Consumer only ever sees committed data; speculative writes stay hidden until commit.
  assign out_valid = (wr_commit_reg != rd_ptr_reg);
  assign rd_en     = out_valid && out_ready;
  assign out_data  = out_valid ? mem[rd_ptr_reg[AW-1:0]][7:0] : 8'd0;
  assign out_last  = out_valid && mem[rd_ptr_reg[AW-1:0]][8];

  always_ff @(posedge clk) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    start      = 1'b0;
    wr_en      = 1'b0;
    eop        = 1'b0;
    set_err    = 1'b0;
    new_err    = E_OK;
    done_err   = E_OK;
    case (state_reg)
      IDLE, DONE: begin
        if (in_valid) begin
          start      = 1'b1;
          state_next = HDR;
        end else begin
          state_next = IDLE;
        end
      end
      HDR: begin
        if (!in_valid) begin
          eop        = 1'b1;
          done_err   = E_TRUNC;
          state_next = DONE;
        end else if (hdr_idx_reg == 4'd5 && len_full < 32'(MIN_LEN)) begin
          set_err    = 1'b1;
          new_err    = E_SHORT;
          state_next = DROP;
        end else if (hdr_idx_reg == 4'd5 && len_full > 32'(MAX_LEN)) begin
          set_err    = 1'b1;
          new_err    = E_LONG;
          state_next = DROP;
        end else if (hdr_idx_reg == 4'd9) begin
          state_next = PAY;
        end
      end
      PAY: begin
        if (!in_valid) begin
          eop        = 1'b1;
          state_next = DONE;
          if (pay_cnt_reg != pay_len)           done_err = E_TRUNC;
          else if (crc_reg != {24'd0, sum_reg}) done_err = E_CRC;
          else                                  done_err = E_OK;
        end else if (fifo_full) begin
          set_err    = 1'b1;
          new_err    = E_OVF;
          state_next = DROP;
        end else if (pay_cnt_reg == pay_len) begin
          set_err    = 1'b1;
          new_err    = E_OVR;
          state_next = DROP;
        end else begin
          wr_en = 1'b1;
        end
      end
      DROP: begin
        if (!in_valid) begin
          eop        = 1'b1;
          done_err   = err_reg;
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_spec_reg[AW-1:0]] <= {wr_last, in_data};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hdr_idx_reg   <= 4'd0;
      sa_reg        <= 8'd0;
      da_reg        <= 8'd0;
      len_reg       <= 32'd0;
      crc_reg       <= 32'd0;
      sum_reg       <= 8'd0;
      pay_cnt_reg   <= 8'd0;
      err_reg       <= E_OK;
      wr_commit_reg <= '0;
      wr_spec_reg   <= '0;
      rd_ptr_reg    <= '0;
      pkt_done      <= 1'b0;
      pkt_err       <= 3'd0;
      sa_o          <= 8'd0;
      da_o          <= 8'd0;
      len_o         <= 32'd0;
      pkt_count     <= 16'd0;
      err_count     <= 16'd0;
    end else begin
      pkt_done <= eop;
      if (start) begin
        sa_reg      <= in_data;
        da_reg      <= 8'd0;
        len_reg     <= 32'd0;
        crc_reg     <= 32'd0;
        hdr_idx_reg <= 4'd1;
        pay_cnt_reg <= 8'd0;
        sum_reg     <= 8'd0;
        err_reg     <= E_OK;
      end
      if (state_reg == HDR && in_valid) begin
        hdr_idx_reg <= hdr_idx_reg + 4'd1;
        case (hdr_idx_reg)
          4'd1: da_reg         <= in_data;
          4'd2: len_reg[7:0]   <= in_data;
          4'd3: len_reg[15:8]  <= in_data;
          4'd4: len_reg[23:16] <= in_data;
          4'd5: len_reg[31:24] <= in_data;
          4'd6: crc_reg[7:0]   <= in_data;
          4'd7: crc_reg[15:8]  <= in_data;
          4'd8: crc_reg[23:16] <= in_data;
          4'd9: crc_reg[31:24] <= in_data;
          default: ;
        endcase
      end
      if (wr_en) begin
        wr_spec_reg <= wr_spec_reg + 1'b1;
        pay_cnt_reg <= pay_cnt_reg + 8'd1;
        sum_reg     <= sum_reg + in_data;
      end
      if (set_err) err_reg <= new_err;
      // Commit publishes the whole packet at once; rollback discards all speculative writes.
      if (eop) begin
        pkt_err <= done_err;
        sa_o    <= sa_reg;
        da_o    <= da_reg;
        len_o   <= len_reg;
        if (done_err == E_OK) begin
          wr_commit_reg <= wr_spec_reg;
          if (pkt_count != 16'hFFFF) pkt_count <= pkt_count + 16'd1;
        end else begin
          wr_spec_reg <= wr_commit_reg;
          if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        end
      end
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: tb/tb_router_egress_deframer.sv
// Directed and randomized bench for router_egress_deframer, checked against a packet-level
// reference model (error classification, payload queue, counters).
module tb_router_egress_deframer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_last;
  logic        out_ready = 1'b0;
  logic        pkt_done;
  logic [2:0]  pkt_err;
  logic [7:0]  sa_o, da_o;
  logic [31:0] len_o;
  logic [15:0] pkt_count, err_count;

  always #5 clk = ~clk;

  router_egress_deframer dut (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .pkt_done(pkt_done), .pkt_err(pkt_err), .sa_o(sa_o), .da_o(da_o), .len_o(len_o),
    .pkt_count(pkt_count), .err_count(err_count)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] pkt[$];
  logic [8:0] exp_q[$];
  int exp_pkts = 0;
  int exp_errs = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic build(input logic [7:0] sa, input logic [7:0] da, input logic [31:0] len,
                       input int npay, input int crc_add, input bit seq);
    logic [7:0]  p[$];
    logic [7:0]  b;
    logic [31:0] crc;
    int s = 0;
    for (int i = 0; i < npay; i++) begin
      b = seq ? 8'(i + 1) : 8'($urandom);
      p.push_back(b);
      s += int'(b);
    end
    crc = 32'((s % 256) + crc_add);
    pkt.delete();
    pkt.push_back(sa);
    pkt.push_back(da);
    for (int k = 0; k < 4; k++) pkt.push_back(len[8*k +: 8]);
    for (int k = 0; k < 4; k++) pkt.push_back(crc[8*k +: 8]);
    foreach (p[i]) pkt.push_back(p[i]);
  endtask

  // Classify the packet in pkt[] from the wire-format rules, given free FIFO space.
  function automatic int model_err(input int free);
    int n = pkt.size();
    logic [31:0] lenv, crcv;
    int need, np, s;
    if (n >= 6) begin
      lenv = {pkt[5], pkt[4], pkt[3], pkt[2]};
      if (lenv < 32'd12) return 2;
      if (lenv > 32'd64) return 3;
    end
    if (n < 10) return 4;
    need = int'(lenv) - 10;
    np = n - 10;
    for (int i = 0; i < np; i++) begin
      if (i >= free) return 6;
      if (i >= need) return 5;
    end
    if (np < need) return 4;
    s = 0;
    for (int i = 10; i < n; i++) s += int'(pkt[i]);
    crcv = {pkt[9], pkt[8], pkt[7], pkt[6]};
    if (crcv != 32'(s % 256)) return 1;
    return 0;
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge where pkt_done must be high.
  task automatic send(input string tag);
    int n = pkt.size();
    int err = model_err(128 - exp_q.size());
    foreach (pkt[i]) begin
      in_valid = 1'b1;
      in_data  = pkt[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_data  = 8'd0;
    @(negedge clk);
    if (err == 0) begin
      for (int i = 10; i < n; i++) exp_q.push_back({(i == n - 1), pkt[i]});
      exp_pkts++;
    end else begin
      exp_errs++;
    end
    $display("pkt %s: bytes=%0d expected_err=%0d observed_err=%0d", tag, n, err, pkt_err);
    chk({tag, " pkt_done"}, 32'(pkt_done), 32'd1);
    chk({tag, " pkt_err"}, 32'(pkt_err), 32'(err));
    chk({tag, " sa_o"}, 32'(sa_o), 32'(pkt[0]));
    if (n >= 2) chk({tag, " da_o"}, 32'(da_o), 32'(pkt[1]));
    if (n >= 6) chk({tag, " len_o"}, len_o, {pkt[5], pkt[4], pkt[3], pkt[2]});
    chk({tag, " pkt_count"}, 32'(pkt_count), 32'(exp_pkts));
    chk({tag, " err_count"}, 32'(err_count), 32'(exp_errs));
    chk({tag, " out_valid"}, 32'(out_valid), 32'(exp_q.size() != 0));
  endtask

  task automatic drain(input string tag, input bit rnd);
    int budget = 5000;
    logic [8:0] e;
    while (exp_q.size() != 0 && budget > 0) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid && out_ready) begin
        e = exp_q.pop_front();
        chk({tag, " out_data"}, 32'(out_data), 32'(e[7:0]));
        chk({tag, " out_last"}, 32'(out_last), 32'(e[8]));
      end
      @(negedge clk);
      budget--;
    end
    out_ready = 1'b0;
    if (exp_q.size() != 0) chk({tag, " drain timeout remaining"}, 32'(exp_q.size()), 32'd0);
    chk({tag, " empty after drain"}, 32'(out_valid), 32'd0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, " out_data"}, 32'(out_data), 32'd0);
    chk({tag, " out_last"}, 32'(out_last), 32'd0);
    chk({tag, " pkt_done"}, 32'(pkt_done), 32'd0);
    chk({tag, " pkt_err"}, 32'(pkt_err), 32'd0);
    chk({tag, " sa_o"}, 32'(sa_o), 32'd0);
    chk({tag, " da_o"}, 32'(da_o), 32'd0);
    chk({tag, " len_o"}, len_o, 32'd0);
    chk({tag, " pkt_count"}, 32'(pkt_count), 32'd0);
    chk({tag, " err_count"}, 32'(err_count), 32'd0);
  endtask

  initial begin
    int mode, len, k;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // Good packet, then drain and check ordering/out_last.
    build(8'd3, 8'd5, 32'd20, 10, 0, 1'b1);
    send("good");
    chk("good pkt_err literal", 32'(pkt_err), 32'd0);
    drain("good", 1'b0);

    build(8'd3, 8'd5, 32'd20, 10, 1, 1'b1);
    send("bad crc");
    chk("bad crc literal", 32'(pkt_err), 32'd1);

    build(8'd3, 8'd5, 32'd11, 10, 0, 1'b1);
    send("short len");
    build(8'd3, 8'd5, 32'd65, 10, 0, 1'b1);
    send("long len");
    build(8'd3, 8'd5, 32'd20, 5, 0, 1'b1);
    send("truncated");
    build(8'd3, 8'd5, 32'd20, 12, 0, 1'b1);
    send("overrun");
    drain("after errors", 1'b0);

    // FIFO fill: two packets commit, the third overflows.
    for (int i = 0; i < 3; i++) begin
      build(8'd7, 8'd9, 32'd60, 50, 0, 1'b0);
      send("fill");
    end
    chk("overflow literal", 32'(pkt_err), 32'd6);
    drain("fill", 1'b0);

    // Reset in the middle of a payload, with committed data still queued.
    build(8'd1, 8'd2, 32'd20, 10, 0, 1'b1);
    send("pre reset");
    build(8'd4, 8'd6, 32'd20, 10, 0, 1'b1);
    for (int i = 0; i < 14; i++) begin
      in_valid = 1'b1;
      in_data  = pkt[i];
      @(negedge clk);
    end
    in_data = pkt[14];
    reset_n = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'd0;
    chk_reset("mid reset");
    reset_n = 1'b1;
    exp_q.delete();
    exp_pkts = 0;
    exp_errs = 0;
    @(negedge clk);
    build(8'd8, 8'd11, 32'd30, 20, 0, 1'b0);
    send("post reset");
    chk("post reset pkt_count literal", 32'(pkt_count), 32'd1);
    drain("post reset", 1'b1);

    // Randomized packets, back to back, with occasional random drains.
    for (int t = 0; t < 40; t++) begin
      mode = $urandom_range(0, 5);
      len  = $urandom_range(12, 64);
      case (mode)
        0, 1: build(8'($urandom), 8'($urandom), 32'(len), len - 10, 0, 1'b0);
        2:    build(8'($urandom), 8'($urandom), 32'(len), len - 10, $urandom_range(1, 255), 1'b0);
        3: begin
          build(8'($urandom), 8'($urandom), 32'(len), len - 10, 0, 1'b0);
          k = $urandom_range(1, len - 1);
          while (pkt.size() > k) void'(pkt.pop_back());
        end
        4:    build(8'($urandom), 8'($urandom), 32'(len), len - 10 + $urandom_range(1, 3), 0, 1'b0);
        default: begin
          if ($urandom_range(0, 1) == 1)
            build(8'($urandom), 8'($urandom), 32'($urandom_range(0, 11)), $urandom_range(0, 20), 0, 1'b0);
          else
            build(8'($urandom), 8'($urandom), 32'($urandom_range(65, 70000)), $urandom_range(0, 20), 0, 1'b0);
        end
      endcase
      send("random");
      if ($urandom_range(0, 3) == 0) drain("random", 1'b1);
    end
    drain("final", 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
